uart_apb_bridge: RTL

UART_APB_BRIDGE -- requirements
Module: uart_apb_bridge

---
 rtl/uart_apb_bridge_pkg.sv | 24 ++
 rtl/uart_apb_bridge.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_apb_bridge_pkg.sv
// Shared definitions for the UART-to-APB command bridge.
// Holds the controller state encoding and the command/response byte values
// exchanged over the UART byte stream.
package uart_apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    SETUP  = 3'd3,
    ACCESS = 3'd4,
    RESP   = 3'd5
  } state_t;

  // Command bytes received from the host
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

  // Response bytes returned to the host
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K' write completed
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E' slave error
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?' unknown command

endpackage

// File: rtl/uart_apb_bridge.sv
// UART byte-stream to APB master bridge.
// The host sends 'W' + 4 address bytes + 4 data bytes, or 'R' + 4 address
// bytes (all MSB-first). The bridge performs one APB transfer and answers with
// 'K' (write ok), 'E' (slave error), the 4 read-data bytes MSB-first, or '?'
// for an unknown command byte.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_data/rx_empty/rx_rd RX FIFO head byte, empty flag, pop strobe
//   tx_wdata/tx_full/tx_wr TX FIFO write byte, full flag, push strobe
//   PADDR..PENABLE         APB master request
//   PRDATA/PREADY/PSLVERR  APB completion
//   busy                   high whenever the controller is not idle
//   timeout_err            one-cycle pulse when a command stalls too long
//
// Handshakes: rx_rd is asserted only while a byte is available
// (rx_rd = !rx_empty in the receiving states) and the byte on rx_data is
// consumed in that same cycle; tx_wr is asserted only when !tx_full and the
// byte on tx_wdata is pushed in that cycle. APB transfers follow the standard
// SETUP (PSEL) then ACCESS (PSEL+PENABLE until PREADY) sequence.
module uart_apb_bridge #(
  parameter logic [15:0] TIMEOUT = 16'd50000  // inter-byte timeout, 0 = off
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_rd,
  output logic [7:0]  tx_wdata,
  input  logic        tx_full,
  output logic        tx_wr,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        busy,
  output logic        timeout_err
);
  import uart_apb_bridge_pkg::*;

  state_t      state, state_nxt;
  logic        op_write;
  logic [1:0]  byte_cnt;
  logic [31:0] resp_sr;
  logic [2:0]  resp_len;
  logic [15:0] tmo_cnt;
  logic        rx_phase, collecting, consume, push, tmo_hit;

  assign rx_phase   = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign collecting = (state == ADDR) || (state == DATA);

  // rx_rd is gated by rst_n so it drops the moment reset asserts, even
  // while the FIFO still reports data.
  assign rx_rd   = rst_n && rx_phase && !rx_empty;
  assign consume = rx_rd;
  assign push    = (state == RESP) && !tx_full;

  assign tx_wr    = push;
  assign tx_wdata = resp_sr[31:24];
  assign PSEL     = (state == SETUP) || (state == ACCESS);
  assign PENABLE  = (state == ACCESS);
  assign PWRITE   = PSEL && op_write;
  assign busy     = (state != IDLE);

  // Fires on the TIMEOUT-th consecutive cycle without a byte while a
  // command is partially received.
  assign tmo_hit = (TIMEOUT != 16'd0) && collecting && !consume &&
                   (tmo_cnt == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (consume) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) state_nxt = ADDR;
          else                                             state_nxt = RESP;
        end
      end
      ADDR: begin
        if (tmo_hit)                           state_nxt = IDLE;
        else if (consume && byte_cnt == 2'd3)  state_nxt = op_write ? DATA : SETUP;
      end
      DATA: begin
        if (tmo_hit)                           state_nxt = IDLE;
        else if (consume && byte_cnt == 2'd3)  state_nxt = SETUP;
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (PREADY) state_nxt = RESP;
      RESP:   if (push && resp_len == 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write    <= 1'b0;
      byte_cnt    <= 2'd0;
      PADDR       <= 32'h0;
      PWDATA      <= 32'h0;
      resp_sr     <= 32'h0;
      resp_len    <= 3'd0;
      tmo_cnt     <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;

      // Counter is held at zero outside ADDR/DATA, so entering ADDR starts
      // from zero; it saturates rather than wrapping when TIMEOUT is 0.
      if (!collecting || consume)  tmo_cnt <= 16'd0;
      else if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (consume) begin
            byte_cnt <= 2'd0;
            op_write <= (rx_data == CMD_WRITE);
            if (rx_data != CMD_WRITE && rx_data != CMD_READ) begin
              resp_sr  <= {RSP_BAD, 24'h0};
              resp_len <= 3'd1;
            end
          end
        end
        ADDR: begin
          if (consume) begin
            PADDR    <= {PADDR[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 after the 4th byte
          end
        end
        DATA: begin
          if (consume) begin
            PWDATA   <= {PWDATA[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        ACCESS: begin
          if (PREADY) begin
            if (PSLVERR) begin
              resp_sr  <= {RSP_ERR, 24'h0};
              resp_len <= 3'd1;
            end else if (op_write) begin
              resp_sr  <= {RSP_ACK, 24'h0};
              resp_len <= 3'd1;
            end else begin
              resp_sr  <= PRDATA;
              resp_len <= 3'd4;
            end
          end
        end
        RESP: begin
          if (push) begin
            resp_sr  <= {resp_sr[23:0], 8'h0};
            resp_len <= resp_len - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
